// File: rtl/spi_tx_arbiter_pkg.sv
// spi_tx_arbiter_pkg: FSM state encodings and default word width shared with the serializer.
package spi_tx_arbiter_pkg;
    localparam int DEF_DATA_SIZE = 32;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;
endpackage

// File: rtl/spi_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set bit of req searching upward from pointer with wrap.
//   req     in  NUM_REQ  request levels
//   pointer in  log2     search start index
//   valid   out 1        any request present
//   index   out log2     winning index
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] index
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest requester is the last write and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(pointer) + i) % NUM_REQ);
            if (req[idx]) begin
                valid = 1'b1;
                index = idx;
            end
        end
    end
endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter feeding one SPI serializer and driving its data-ready/ready handshake.
//   i_Clock, i_Reset (async, active-high)
//   i_Req/i_Req_Data       requester levels and packed words
//   o_Grant/o_Done/o_Error one-hot single-cycle status pulses per requester
//   o_Busy                 transfer in ISSUE or BUSY
//   o_Ser_Data/o_Ser_Data_Ready/i_Ser_Ready  serializer handshake
module spi_tx_arbiter
    import spi_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int TIMEOUT   = 16
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [NUM_REQ-1:0]           i_Req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]           o_Grant,
    output logic [NUM_REQ-1:0]           o_Done,
    output logic [NUM_REQ-1:0]           o_Error,
    output logic                         o_Busy,
    output logic [DATA_SIZE-1:0]         o_Ser_Data,
    output logic                         o_Ser_Data_Ready,
    input  logic                         i_Ser_Ready
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, g_q, g_d, pick_idx, ptr_nxt;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, error_q, error_d;
    logic                 busy_q, busy_d, rdy_q, rdy_d, pick_valid;
    logic [DATA_SIZE-1:0] data_q, data_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (i_Req),
        .pointer (ptr_q),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    assign ptr_nxt = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        data_d  = data_q;
        grant_d = '0;
        done_d  = '0;
        error_d = '0;
        case (state_q)
            IDLE: if (i_Ser_Ready && pick_valid) begin
                data_d  = i_Req_Data[int'(pick_idx)*DATA_SIZE +: DATA_SIZE];
                g_d     = pick_idx;
                grant_d = NUM_REQ'(1) << pick_idx;
                rdy_d   = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: if (!i_Ser_Ready) begin
                rdy_d   = 1'b0;
                state_d = BUSY;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                // Serializer never accepted the word: give up and move the pointer past g.
                rdy_d   = 1'b0;
                error_d = NUM_REQ'(1) << g_q;
                ptr_d   = ptr_nxt;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            BUSY: if (i_Ser_Ready) begin
                done_d  = NUM_REQ'(1) << g_q;
                ptr_d   = ptr_nxt;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_Grant          = grant_q;
    assign o_Done           = done_q;
    assign o_Error          = error_q;
    assign o_Busy           = busy_q;
    assign o_Ser_Data       = data_q;
    assign o_Ser_Data_Ready = rdy_q;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed table and corner sequences for spi_tx_arbiter with a behavioural serializer.
module tb_spi_tx_arbiter;
    localparam int SER_LEN = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   i_Req = '0;
    logic [127:0] i_Req_Data = '0;
    logic [3:0]   o_Grant, o_Done, o_Error;
    logic         o_Busy, o_Ser_Data_Ready;
    logic [31:0]  o_Ser_Data;
    logic         ser_ready = 1'b1;
    logic         stuck = 1'b0;
    logic [31:0]  cap_word = '0;
    int           ser_cnt = 0;
    int           tests = 0;
    int           fails = 0;

    spi_tx_arbiter #(.NUM_REQ(4), .DATA_SIZE(32), .TIMEOUT(16)) dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_Req            (i_Req),
        .i_Req_Data       (i_Req_Data),
        .o_Grant          (o_Grant),
        .o_Done           (o_Done),
        .o_Error          (o_Error),
        .o_Busy           (o_Busy),
        .o_Ser_Data       (o_Ser_Data),
        .o_Ser_Data_Ready (o_Ser_Data_Ready),
        .i_Ser_Ready      (ser_ready)
    );

    always #5 clk = ~clk;

    // Serializer model: accepts a word when ready and data-ready meet, stays busy SER_LEN cycles,
    // and ignores the arbiter reset like the real serializer. stuck forces ready high without accepting.
    always @(posedge clk) begin
        #2;
        if (stuck) ser_ready = 1'b1;
        else if (ser_ready && o_Ser_Data_Ready) begin
            cap_word  = o_Ser_Data;
            ser_ready = 1'b0;
            ser_cnt   = SER_LEN;
        end else if (!ser_ready) begin
            if (ser_cnt <= 1) ser_ready = 1'b1;
            else ser_cnt--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int lat, output logic [3:0] g);
        lat = 0;
        g   = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            lat++;
            if (o_Grant != 0) begin
                g = o_Grant;
                break;
            end
        end
    endtask

    task automatic wait_done(input logic [3:0] eg, input logic [31:0] ew);
        logic [3:0] dn = '0;
        bit stable = 1'b1, err = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_Ser_Data !== ew) stable = 1'b0;
            if (o_Error != 0) err = 1'b1;
            if (o_Done != 0) begin
                dn = o_Done;
                break;
            end
        end
        check("done", 64'(dn), 64'(eg));
        check("data_stable", 64'(stable), 64'd1);
        check("no_error", 64'(err), 64'd0);
        check("ser_word", 64'(cap_word), 64'(ew));
    endtask

    task automatic xfer(input logic [3:0] req, input logic [127:0] data, input logic [3:0] eg,
                        input logic [31:0] ew, input bit drop);
        int lat;
        logic [3:0] g;
        i_Req = req;
        i_Req_Data = data;
        wait_grant(lat, g);
        check("grant_lat", 64'(lat), 64'd1);
        check("grant", 64'(g), 64'(eg));
        check("grant_data", 64'(o_Ser_Data), 64'(ew));
        check("grant_busy", 64'(o_Busy), 64'd1);
        if (drop) i_Req = '0;
        wait_done(eg, ew);
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [127:0] data;
        logic [3:0]   grant;
        logic [31:0]  word;
    } vec_t;

    localparam logic [127:0] D_ALL = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] D_A5  = {32'h44444444, 32'hA5A50F0F, 32'h22222222, 32'h11111111};

    initial begin
        vec_t vt[12];
        int lat, n;
        logic [3:0] g;
        bit bad, early, prev_ready;
        vt[0]  = '{4'b0100, D_A5,  4'b0100, 32'hA5A50F0F};
        vt[1]  = '{4'b1111, D_ALL, 4'b1000, 32'h44444444};
        vt[2]  = '{4'b1111, D_ALL, 4'b0001, 32'h11111111};
        vt[3]  = '{4'b1111, D_ALL, 4'b0010, 32'h22222222};
        vt[4]  = '{4'b1111, D_ALL, 4'b0100, 32'h33333333};
        vt[5]  = '{4'b1111, D_ALL, 4'b1000, 32'h44444444};
        vt[6]  = '{4'b0110, D_ALL, 4'b0010, 32'h22222222};
        vt[7]  = '{4'b0110, D_ALL, 4'b0100, 32'h33333333};
        vt[8]  = '{4'b1111, D_ALL, 4'b1000, 32'h44444444};
        vt[9]  = '{4'b0001, D_ALL, 4'b0001, 32'h11111111};
        vt[10] = '{4'b1001, D_ALL, 4'b1000, 32'h44444444};
        vt[11] = '{4'b1001, D_ALL, 4'b0001, 32'h11111111};

        repeat (3) @(negedge clk);
        check("rst_grant", 64'(o_Grant | o_Done | o_Error), 64'd0);
        check("rst_busy", 64'({o_Busy, o_Ser_Data_Ready}), 64'd0);
        check("rst_data", 64'(o_Ser_Data), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) xfer(vt[i].req, vt[i].data, vt[i].grant, vt[i].word, 1'b0);

        // Timeout: serializer never drops ready.
        stuck = 1'b1;
        i_Req = 4'b0001;
        i_Req_Data = {96'h0, 32'hDEADBEEF};
        wait_grant(lat, g);
        check("to_grant", 64'(g), 64'd1);
        n = 0;
        bad = 1'b0;
        while (o_Ser_Data_Ready && n < 100) begin
            n++;
            @(negedge clk);
            if (o_Done != 0) bad = 1'b1;
        end
        check("to_ready_cycles", 64'(n), 64'd16);
        check("to_error", 64'(o_Error), 64'd1);
        check("to_busy", 64'(o_Busy), 64'd0);
        check("to_no_done", 64'(bad), 64'd0);
        stuck = 1'b0;
        xfer(4'b0011, D_ALL, 4'b0010, 32'h22222222, 1'b0);

        // Reset while ISSUE holds data-ready high.
        stuck = 1'b1;
        i_Req = 4'b0100;
        wait_grant(lat, g);
        check("ri_grant", 64'(g), 64'b0100);
        repeat (3) @(negedge clk);
        check("ri_ready_before", 64'(o_Ser_Data_Ready), 64'd1);
        #2 rst = 1'b1;
        #1 check("ri_async_ready", 64'(o_Ser_Data_Ready), 64'd0);
        check("ri_async_busy", 64'(o_Busy), 64'd0);
        @(negedge clk);
        i_Req = '0;
        stuck = 1'b0;
        rst = 1'b0;

        // Reset mid-BUSY: the serializer keeps running, so no grant until its ready returns.
        i_Req = 4'b0001;
        wait_grant(lat, g);
        check("rb_grant", 64'(g), 64'b0001);
        repeat (10) @(negedge clk);
        check("rb_busy_before", 64'(o_Busy), 64'd1);
        #2 rst = 1'b1;
        #1 check("rb_async_busy", 64'(o_Busy), 64'd0);
        check("rb_async_data", 64'(o_Ser_Data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        i_Req = 4'b0010;
        prev_ready = ser_ready;
        bad = 1'b0;
        early = 1'b0;
        n = 0;
        g = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if ((o_Done | o_Error) != 0) bad = 1'b1;
            if (o_Grant != 0) begin
                g = o_Grant;
                if (!prev_ready) early = 1'b1;
                break;
            end
            prev_ready = ser_ready;
        end
        check("rb_grant_after", 64'(g), 64'b0010);
        check("rb_no_early_grant", 64'(early), 64'd0);
        check("rb_waited", 64'(n > 1), 64'd1);
        check("rb_no_stale_status", 64'(bad), 64'd0);
        wait_done(4'b0010, 32'h22222222);

        // Requester drops its level right after grant; transfer still completes.
        xfer(4'b0001, D_ALL, 4'b0001, 32'h11111111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
